// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link constants and slave state encoding
package spi_pkg;

  localparam int         SPI_DATA_WIDTH  = 8;
  localparam int         SPI_SYNC_STAGES = 2;
  localparam logic [7:0] SPI_DEFAULT_TX  = 8'h00;

  typedef enum logic {
    SPI_SLV_IDLE   = 1'b0,
    SPI_SLV_ACTIVE = 1'b1
  } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with optional rise/fall detector
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0,
  parameter bit   EDGE_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  // shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {SYNC_STAGES{RESET_VAL}};
    else     sync <= {sync[SYNC_STAGES-2:0], d};
  end

  assign q = sync[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;

      // one extra flop on the synced level gives a single-cycle edge strobe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= RESET_VAL;
        else     prev <= q;
      end

      assign rise = ~prev & q;
      assign fall = prev & ~q;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 slave with byte-parallel rx/tx handshake in the clk domain
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int            CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_n_sync, mosi_s;
  logic unused_ss_rise, unused_ss_fall, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss), .q(ss_n_sync), .rise(unused_ss_rise), .fall(unused_ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_slv_state_e        state;
  // miso carries the current tx MSB; tx_shift holds the bits still to follow it
  logic [DATA_WIDTH-2:0] tx_shift;
  // rx_shift holds the bits received so far; the final bit goes straight into rx_data
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  word_done;

  logic                  load;
  logic                  wr;
  logic [DATA_WIDTH-1:0] load_word;

  // a tx load happens on frame entry and on the first falling sclk after each completed word
  always_comb begin
    load      = 1'b0;
    if (state == SPI_SLV_IDLE)
      load = ~ss_n_sync;
    else
      load = ~ss_n_sync & sclk_fall & word_done;
    load_word = hold_full ? hold_data : DEFAULT_TX;
    wr        = tx_valid & ~hold_full;
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state == SPI_SLV_ACTIVE);

  // frame FSM, shift registers, holding register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SPI_SLV_IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // a load empties a full register; a write on an empty one is held for the next load
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (wr) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        SPI_SLV_IDLE: begin
          if (!ss_n_sync) begin
            state     <= SPI_SLV_ACTIVE;
            tx_shift  <= load_word[DATA_WIDTH-2:0];
            miso      <= load_word[DATA_WIDTH-1];
            miso_oe   <= 1'b1;
            bit_cnt   <= '0;
            word_done <= 1'b0;
          end
        end
        SPI_SLV_ACTIVE: begin
          if (ss_n_sync) begin
            // deselect wins over any edge seen in the same cycle
            state     <= SPI_SLV_IDLE;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            frame_err <= (bit_cnt != '0);
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
            if (bit_cnt == LAST) begin
              rx_data   <= {rx_shift, mosi_s};
              rx_valid  <= 1'b1;
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (word_done) begin
              tx_shift  <= load_word[DATA_WIDTH-2:0];
              miso      <= load_word[DATA_WIDTH-1];
              word_done <= 1'b0;
            end else if (bit_cnt != '0) begin
              miso     <= tx_shift[DATA_WIDTH-2];
              tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
            end
          end
        end
        default: state <= SPI_SLV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave against a behavioural SPI model
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, frame_err, busy;
  logic [7:0] rx_data;

  spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: one-entry tx holding register, expected rx words, pending frame errors
  logic [7:0] m_hold   = 8'h00;
  bit         m_full   = 1'b0;
  logic [7:0] last_rx  = 8'h00;
  logic [7:0] exp_rx[$];
  int         exp_ferr = 0;
  bit         in_frame = 1'b0;
  bit         idle_chk = 1'b0;
  logic [7:0] e_rx;

  logic [7:0] mo[4];
  logic [7:0] cap[4];
  logic [7:0] exp_tx[5];
  int         dw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // word the slave must shift out at a load: held word if present, otherwise the default
  function automatic logic [7:0] model_load();
    if (m_full) begin
      m_full = 1'b0;
      return m_hold;
    end
    return SPI_DEFAULT_TX;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},      miso,      0);
    check({tag, "_miso_oe"},   miso_oe,   0);
    check({tag, "_tx_ready"},  tx_ready,  1);
    check({tag, "_rx_data"},   rx_data,   0);
    check({tag, "_rx_valid"},  rx_valid,  0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_busy"},      busy,      0);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    check("tx_ready_before_write", tx_ready, !m_full);
    tx_valid = 1'b1;
    tx_data  = d;
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // master side of one frame: nw words from mo[], optional early stop after abort_at sclk rises
  task automatic spi_frame(input int nw, input int abort_at, input bit do_rst,
                           input bit mid_wr, input logic [7:0] mid_d, output int done_words);
    int     bc;
    bit     stop;
    longint t0;
    bc = 0;
    stop = 1'b0;
    done_words = 0;
    idle_chk = 1'b0;
    ss = 1'b0;
    exp_tx[0] = model_load();
    #80;
    in_frame = 1'b1;
    check("tx_ready_entry", tx_ready, !m_full);
    for (int w = 0; w < nw && !stop; w++) begin
      for (int b = 7; b >= 0; b--) begin
        mosi = mo[w][b];
        #80;
        sclk = 1'b1;
        cap[w][b] = miso;
        bc++;
        if (b == 0) exp_rx.push_back(mo[w]);
        t0 = $time;
        if (mid_wr && w == 0 && b == 5) tx_write(mid_d);
        #(t0 + 80 - $time);
        sclk = 1'b0;
        if (b == 0) begin
          exp_tx[w+1] = model_load();
          done_words  = w + 1;
        end
        if (bc == abort_at) begin
          stop = 1'b1;
          break;
        end
      end
    end
    #80;
    in_frame = 1'b0;
    if (do_rst) begin
      #3;
      last_rx = 8'h00;
      m_full  = 1'b0;
      m_hold  = 8'h00;
      rst = 1'b1;
      ss  = 1'b1;
      #1;
      check_reset_values("midframe_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      ss = 1'b1;
      if (bc % 8 != 0) exp_ferr++;
    end
    mosi = 1'b0;
    #100;
    idle_chk = 1'b1;
    for (int w = 0; w < done_words; w++) check($sformatf("master_rx_word%0d", w), cap[w], exp_tx[w]);
  endtask

  // per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        check("rx_valid_unexpected", rx_valid, 0);
      end else begin
        e_rx = exp_rx.pop_front();
        check("rx_data_on_valid", rx_data, e_rx);
        last_rx = e_rx;
      end
    end else begin
      check("rx_data_held", rx_data, last_rx);
    end
    if (frame_err) begin
      check("frame_err_expected", exp_ferr > 0, 1);
      if (exp_ferr > 0) exp_ferr--;
    end
    if (in_frame) begin
      check("miso_oe_in_frame", miso_oe, 1);
      check("busy_in_frame", busy, 1);
    end
    if (idle_chk) begin
      check("miso_oe_idle", miso_oe, 0);
      check("busy_idle", busy, 0);
      check("miso_idle", miso, 0);
    end
  end

  int nw_r, ab_r;
  bit mid_r;

  initial begin
    #23;
    check_reset_values("power_on");
    @(negedge clk);
    rst = 1'b0;
    #50;
    idle_chk = 1'b1;

    // held word goes out, rx word is delivered
    tx_write(8'hA5);
    check("tx_ready_after_write", tx_ready, 0);
    mo[0] = 8'h32;
    spi_frame(1, 0, 1'b0, 1'b0, 8'h00, dw);
    check("t1_model_tx", exp_tx[0], 8'hA5);
    check("t1_master_rx", cap[0], 8'hA5);
    check("t1_rx_data", rx_data, 8'h32);
    check("t1_tx_ready", tx_ready, 1);

    // back-to-back words, second tx word written during the first
    tx_write(8'h11);
    mo[0] = 8'h32;
    mo[1] = 8'hAA;
    spi_frame(2, 0, 1'b0, 1'b1, 8'h22, dw);
    check("t2_master_rx0", cap[0], 8'h11);
    check("t2_master_rx1", cap[1], 8'h22);
    check("t2_rx_data", rx_data, 8'hAA);

    // nothing written: default word goes out
    mo[0] = 8'hFF;
    spi_frame(1, 0, 1'b0, 1'b0, 8'h00, dw);
    check("t3_master_rx", cap[0], 8'h00);
    check("t3_rx_data", rx_data, 8'hFF);

    // deselect after 3 bits, then a clean frame
    mo[0] = 8'h96;
    spi_frame(1, 3, 1'b0, 1'b0, 8'h00, dw);
    check("t4_rx_unchanged", rx_data, 8'hFF);
    check("t4_ferr_seen", exp_ferr, 0);
    check("t4_miso_oe", miso_oe, 0);
    mo[0] = 8'h5A;
    spi_frame(1, 0, 1'b0, 1'b0, 8'h00, dw);
    check("t4_rx_data", rx_data, 8'h5A);

    // reset after 5 bits, then a clean frame
    tx_write(8'h3E);
    mo[0] = 8'h81;
    spi_frame(1, 5, 1'b1, 1'b0, 8'h00, dw);
    mo[0] = 8'hC3;
    spi_frame(1, 0, 1'b0, 1'b0, 8'h00, dw);
    check("t5_rx_data", rx_data, 8'hC3);
    check("t5_master_rx", cap[0], 8'h00);

    // second write while full is ignored
    tx_write(8'h77);
    tx_write(8'h88);
    check("t6_tx_ready_full", tx_ready, 0);
    mo[0] = 8'h3C;
    spi_frame(1, 0, 1'b0, 1'b0, 8'h00, dw);
    check("t6_master_rx", cap[0], 8'h77);
    mo[0] = 8'h0F;
    spi_frame(1, 0, 1'b0, 1'b0, 8'h00, dw);
    check("t6_no_overwrite", cap[0], 8'h00);

    // randomized frames
    for (int i = 0; i < 20; i++) begin
      nw_r = int'($urandom_range(1, 3));
      for (int w = 0; w < 4; w++) mo[w] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      mid_r = 1'($urandom_range(0, 1));
      ab_r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nw_r * 8 - 1)) : 0;
      spi_frame(nw_r, ab_r, 1'b0, mid_r, 8'($urandom), dw);
    end

    #200;
    check("rx_queue_drained", exp_rx.size(), 0);
    check("frame_err_drained", exp_ferr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Peripheral-side end of the team's SPI link; answers the SPI master block.
- Receives serial bytes on mosi and returns serial bytes on miso, framed by an active-low ss and clocked by the master's sclk.
- Runs entirely in the local clk domain: sclk, ss and mosi are synchronised and edge-detected, and sclk is never used as a clock.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first; presents a byte-parallel rx/tx handshake to local logic.

Parameters:
DATA_WIDTH, 8, bits per SPI word
SYNC_STAGES, 2, flip-flop stages on each of sclk/ss/mosi (minimum 2)
DEFAULT_TX, 8'h00, word shifted out when no tx word is pending

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency
rst  input  1  reset, asynchronous, active-high
sclk  input  1  serial clock from master (asynchronous)
ss  input  1  slave select from master, active-low (asynchronous)
mosi  input  1  serial data from master
miso  output  1  serial data to master
miso_oe  output  1  miso drive enable; 1 only while selected
tx_data  input  DATA_WIDTH  next word to send
tx_valid  input  1  tx_data offered
tx_ready  output  1  one-entry tx holding register empty
rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes
rx_valid  output  1  one-cycle pulse when rx_data updates
frame_err  output  1  one-cycle pulse when ss deasserts mid-word
busy  output  1  in the ACTIVE state

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst. All flops clear on rst, including mid-frame.
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - Tx holding register empty; bit counter 0; state IDLE; synchroniser flops at idle levels (sclk=0, ss=1).
- Synchronisers and edge detection:
  - sclk, ss and mosi each pass through SYNC_STAGES flops.
  - An extra flop on synced sclk gives sclk_rise (prev 0, now 1) and sclk_fall (prev 1, now 0).
  - ss_n_sync is the synced ss.
- IDLE -> ACTIVE when ss_n_sync = 0:
  - Same cycle: load the tx shift register with the holding register if full (then mark it empty), else with DEFAULT_TX.
  - Next cycle: miso = shift[MSB] and miso_oe = 1.
  - Latency from the ss falling pin edge to valid miso is SYNC_STAGES+1 clk cycles, which is within half an sclk period given the clk/sclk ratio.
- ACTIVE, on sclk_rise:
  - rx_shift = {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH: rx_data = the completed word, rx_valid pulses for exactly 1 clk, bit_cnt = 0.
- ACTIVE, on sclk_fall:
  - Mid-word (bit_cnt != 0): shift tx left by 1; miso shows the new MSB.
  - After a completed word (bit_cnt == 0 following a completion): reload the tx shift register from the holding register or DEFAULT_TX, exactly as on entry. This supports back-to-back words with no gap.
- ACTIVE -> IDLE when ss_n_sync = 1:
  - miso_oe = 0 and miso = 0 next cycle; bit_cnt = 0.
  - If bit_cnt != 0, the partial word is discarded: no rx_valid, frame_err pulses 1 clk, rx_data is unchanged.
  - The holding register is unaffected.
- Tx handshake:
  - tx_ready = ~full. A write occurs when tx_valid & tx_ready.
  - If a write and a load happen in the same cycle with the register empty, the load uses DEFAULT_TX and the written word stays held for the next word.
  - tx_valid while full is ignored; there is no overwrite.
- No rx backpressure: the consumer must take rx_data within one word time, otherwise it is overwritten.
- If sclk_rise and a deasserting ss are seen in the same cycle, ss wins: the edge is ignored.
- Edges while IDLE are ignored.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_DATA_WIDTH = 8, SPI_SYNC_STAGES = 2, SPI_DEFAULT_TX.
  - State encoding SPI_SLV_IDLE / SPI_SLV_ACTIVE, so that bench and master share these constants.
- One sub-module: spi_sync_edge.
  - Parameterised SYNC_STAGES synchroniser with an optional rise/fall detector.
  - Instanced 3x: for sclk, ss and mosi (edges needed on sclk only).

Test Plan:
- Write tx 0xA5 while idle, then master sends 0x32 -> rx_valid one pulse with rx_data=0x32; master captures 0xA5; tx_ready returns to 1 at ss entry.
- Back-to-back frame with tx 0x11 then 0x22 written during the first word; master sends 0x32, 0xAA without raising ss -> rx pulses 0x32 then 0xAA; master receives 0x11, 0x22.
- Frame with no tx written; master sends 0xFF -> master receives 0x00 (DEFAULT_TX); rx_data=0xFF.
- Raise ss after 3 sclk rises -> no rx_valid, frame_err 1-cycle pulse, miso_oe=0. Next frame 0x5A received correctly.
- Assert rst after bit 5 of a byte -> all outputs at reset values; the following full frame 0xC3 is received correctly.
- Hold tx_valid with 0x77 then 0x88 while full -> tx_ready=0, 0x88 is not accepted; master receives 0x77.
